// File: rtl/input_control.sv
// input_control
//   Per-digit user-entry counter for the number-guessing game. Each of the
//   three decimal digit registers advances by one on every rising clk edge
//   while its pushbutton is held, wrapping from DIGIT_MAX back to 0. Only
//   digits inside the selected game width respond; the others keep their value.
//
// Ports
//   clk             system clock, rising-edge active
//   restart         asynchronous active-high clear of all digits
//   max_digits[1:0] number of active digits (0 = none .. 3 = all three)
//   pushbuttons[2:0] level-sensitive increment requests, bit n-1 -> digit n
//   update_digit_1  registered value of digit 1 (first digit)
//   update_digit_2  registered value of digit 2
//   update_digit_3  registered value of digit 3
module input_control #(
  parameter int DIGIT_MAX = 9
) (
  input  logic       clk,
  input  logic       restart,
  input  logic [1:0] max_digits,
  input  logic [2:0] pushbuttons,
  output logic [3:0] update_digit_1,
  output logic [3:0] update_digit_2,
  output logic [3:0] update_digit_3
);

  localparam logic [3:0] MAX_VAL = 4'(DIGIT_MAX);

  logic [2:0][3:0] digit_value;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      logic       enable;
      logic [3:0] digit_reg;
      logic [3:0] digit_next;

      // Digit gi+1 is live when max_digits >= gi+1.
      assign enable = (max_digits > 2'(gi));

      always_comb begin
        digit_next = digit_reg;
        if (enable && pushbuttons[gi]) begin
          // ">=" so an out-of-range value collapses to 0 on the next press.
          if (digit_reg >= MAX_VAL) begin
            digit_next = 4'd0;
          end else begin
            digit_next = digit_reg + 4'd1;
          end
        end
      end

      always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
          digit_reg <= 4'd0;
        end else begin
          digit_reg <= digit_next;
        end
      end

      assign digit_value[gi] = digit_reg;
    end
  endgenerate

  // Digits are independent: no carry from one wrap into the next digit.
  assign update_digit_1 = digit_value[0];
  assign update_digit_2 = digit_value[1];
  assign update_digit_3 = digit_value[2];

endmodule

// File: tb/tb_input_control.sv
module tb_input_control;

  logic       clk;
  logic       restart;
  logic [1:0] max_digits;
  logic [2:0] pushbuttons;
  logic [3:0] update_digit_1;
  logic [3:0] update_digit_2;
  logic [3:0] update_digit_3;

  int total;
  int bad;

  input_control #(.DIGIT_MAX(9)) dut (
    .clk            (clk),
    .restart        (restart),
    .max_digits     (max_digits),
    .pushbuttons    (pushbuttons),
    .update_digit_1 (update_digit_1),
    .update_digit_2 (update_digit_2),
    .update_digit_3 (update_digit_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is a few hundred cycles; anything far longer is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run did not finish");
    $fatal(1, "watchdog expired");
  end

  // Pulse restart between edges so every test starts from 0,0,0.
  task automatic do_restart();
    pushbuttons = 3'b000;
    restart = 1'b1;
    #2;
    restart = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    restart     = 1'b1;
    max_digits  = 2'd3;
    pushbuttons = 3'b111;
    #1;
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL reset_initial: got %03h required 000", got);
    end
    $display("reset_initial: digits=%03h", got);
    for (int i = 0; i < 4; i++) begin
      pushbuttons = (i % 2 == 0) ? 3'b111 : 3'b000;
      @(posedge clk);
      @(negedge clk);
      got = {update_digit_3, update_digit_2, update_digit_1};
      total++;
      if (got !== 12'h000) begin
        bad++;
        $display("FAIL reset_held_%0d: got %03h required 000", i, got);
      end
      $display("reset_held_%0d: pb=%b digits=%03h", i, pushbuttons, got);
    end
    // Release between edges; the next edge should count once.
    pushbuttons = 3'b111;
    restart = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h111) begin
      bad++;
      $display("FAIL reset_release: got %03h required 111", got);
    end
    $display("reset_release: digits=%03h", got);
    pushbuttons = 3'b000;
  endtask

  task automatic test_single_digit();
    logic [11:0] got;
    logic [11:0] exp;
    do_restart();
    max_digits  = 2'd1;
    pushbuttons = 3'b001;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      got = {update_digit_3, update_digit_2, update_digit_1};
      exp = {8'h00, 4'(i % 10)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_edge_%0d: got %03h required %03h", i, got, exp);
      end
      $display("single_edge_%0d: digits=%03h", i, got);
    end
    pushbuttons = 3'b000;
  endtask

  task automatic test_disabled_mask();
    logic [11:0] got;
    do_restart();
    max_digits  = 2'd1;
    pushbuttons = 3'b111;
    repeat (5) @(posedge clk);
    @(negedge clk);
    pushbuttons = 3'b000;
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h005) begin
      bad++;
      $display("FAIL disabled_mask: got %03h required 005", got);
    end
    $display("disabled_mask: digits=%03h", got);
  endtask

  task automatic test_two_digits();
    logic [11:0] got;
    logic [11:0] exp;
    do_restart();
    max_digits  = 2'd2;
    pushbuttons = 3'b011;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      got = {update_digit_3, update_digit_2, update_digit_1};
      exp = {4'h0, 4'(i % 10), 4'(i % 10)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL two_edge_%0d: got %03h required %03h", i, got, exp);
      end
      $display("two_edge_%0d: digits=%03h", i, got);
    end
    pushbuttons = 3'b000;
  endtask

  task automatic test_three_then_reduce();
    logic [11:0] got;
    logic [11:0] exp;
    do_restart();
    max_digits  = 2'd3;
    pushbuttons = 3'b111;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 9 || i == 10 || i == 20 || i == 25) begin
        got = {update_digit_3, update_digit_2, update_digit_1};
        exp = {3{4'(i % 10)}};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL three_edge_%0d: got %03h required %03h", i, got, exp);
        end
        $display("three_edge_%0d: digits=%03h", i, got);
      end
    end
    // Shrink width: digit 3 must freeze at 5 while 1-2 keep counting.
    max_digits = 2'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pushbuttons = 3'b000;
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h588) begin
      bad++;
      $display("FAIL reduce_width: got %03h required 588", got);
    end
    $display("reduce_width: digits=%03h", got);
    // Re-enable digit 3: it resumes from its retained 5.
    max_digits  = 2'd3;
    pushbuttons = 3'b100;
    @(posedge clk);
    @(negedge clk);
    pushbuttons = 3'b000;
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h688) begin
      bad++;
      $display("FAIL reenable: got %03h required 688", got);
    end
    $display("reenable: digits=%03h", got);
  endtask

  task automatic test_none_and_async();
    logic [11:0] got;
    // Starts from 6,8,8 left by the previous task.
    max_digits  = 2'd0;
    pushbuttons = 3'b111;
    repeat (4) @(posedge clk);
    @(negedge clk);
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h688) begin
      bad++;
      $display("FAIL none_enabled: got %03h required 688", got);
    end
    $display("none_enabled: digits=%03h", got);
    // Assert restart mid-cycle; outputs must clear before the next edge.
    max_digits = 2'd3;
    #2;
    restart = 1'b1;
    #1;
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL async_clear: got %03h required 000", got);
    end
    $display("async_clear: digits=%03h", got);
    // Held across an edge with buttons pressed: still zero.
    @(posedge clk);
    #1;
    got = {update_digit_3, update_digit_2, update_digit_1};
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL async_hold_edge: got %03h required 000", got);
    end
    $display("async_hold_edge: digits=%03h", got);
    @(negedge clk);
    restart = 1'b0;
    pushbuttons = 3'b000;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    restart     = 1'b1;
    max_digits  = 2'd0;
    pushbuttons = 3'b000;
    test_reset();
    test_single_digit();
    test_disabled_mask();
    test_two_digits();
    test_three_then_reduce();
    test_none_and_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
